// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Combinational full adder composed of two half adders and an OR on their carries.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0, c0, c1;

  halfAdder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  halfAdder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));
  or_gate   u_or  (.a(c0), .b(c1),  .y(cout));

endmodule

// File: rtl/halfAdder.sv
// Gate-level half adder cell.
module halfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/or_gate.sv
// Two-input OR cell.
module or_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a | b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are added LSB-first through one full
// adder with a registered carry; the result is published with a done pulse.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_sr_q, b_sr_q, sum_sr_q, sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q, cout_q, busy_q, done_q;

  logic               fa_s, fa_co;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   sum_sr_d;
  logic               last_bit;

  full_adder u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_co)
  );

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no slice.
  assign sum_ext  = {fa_s, sum_sr_q};
  assign sum_sr_d = sum_ext[WIDTH:1];
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          sum_sr_q <= sum_sr_d;
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          carry_q  <= fa_co;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            sum_q   <= sum_sr_d;
            cout_q  <= fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
